// File: rtl/bist_fault_collector_if.sv
// Bus between the BIST fault collector, the eNVM pattern/fault storage
// and the systolic array scan comparator.
interface bist_fault_collector_if #(
    parameter int SYSTOLIC_SIZE          = 8,
    parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH  = 12,
    parameter int TD_TEST_PATTERN_DEPTH  = 18,
    parameter int MAX_PATTERN_ADDR_WIDTH =
        $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
               SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH)
);
    logic                                     start;
    logic                                     test_type_in;
    logic                                     test_type;
    logic [MAX_PATTERN_ADDR_WIDTH-1:0]        test_counter;
    logic                                     TD_answer_choose;
    logic                                     pattern_req;
    logic                                     result_valid;
    logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0]   pe_mismatch;
    logic                                     detection_en;
    logic [ADDR_WIDTH-1:0]                    detection_addr;
    logic [SYSTOLIC_SIZE-1:0]                 single_pe_detection;
    logic [SYSTOLIC_SIZE-1:0]                 row_fault_detection;
    logic [SYSTOLIC_SIZE-1:0]                 column_fault_detection;
    logic                                     busy;
    logic                                     done;
    logic                                     fault_found;

    // The collector drives the sequencing and detection results.
    modport master (
        input  start, test_type_in, result_valid, pe_mismatch,
        output test_type, test_counter, TD_answer_choose, pattern_req,
               detection_en, detection_addr, single_pe_detection,
               row_fault_detection, column_fault_detection,
               busy, done, fault_found
    );

    // The surrounding environment (eNVM, scan comparator, controller).
    modport slave (
        output start, test_type_in, result_valid, pe_mismatch,
        input  test_type, test_counter, TD_answer_choose, pattern_req,
               detection_en, detection_addr, single_pe_detection,
               row_fault_detection, column_fault_detection,
               busy, done, fault_found
    );
endinterface

// File: rtl/bist_fault_collector.sv
// BIST sequencer and fault collector: steps through SA or TD patterns,
// accumulates the per-PE mismatch map, classifies row/column/isolated
// faults and writes them to the eNVM one array row per cycle.
module bist_fault_collector #(
    parameter int SYSTOLIC_SIZE          = 8,
    parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
    parameter int SA_TEST_PATTERN_DEPTH  = 12,
    parameter int TD_TEST_PATTERN_DEPTH  = 18,
    parameter int MAX_PATTERN_ADDR_WIDTH =
        $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
               SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH),
    parameter int LINE_FAULT_THRESHOLD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    bist_fault_collector_if.master bus
);
    localparam int S       = SYSTOLIC_SIZE;
    localparam int CNT_W   = $clog2(SYSTOLIC_SIZE) + 1;
    localparam int PCW     = MAX_PATTERN_ADDR_WIDTH;

    localparam logic [PCW-1:0]        SA_LAST     = PCW'(SA_TEST_PATTERN_DEPTH - 1);
    localparam logic [PCW-1:0]        TD_LAST     = PCW'(TD_TEST_PATTERN_DEPTH - 1);
    localparam logic [PCW-1:0]        PAT_ONE     = PCW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      LINE_THRESH = CNT_W'(LINE_FAULT_THRESHOLD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EVAL,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              testType_q, testType_d;
    logic [PCW-1:0]    testCounter_q, testCounter_d;
    logic              choose_q, choose_d;
    logic [S*S-1:0]    faultMap_q, faultMap_d;
    logic              faultFound_q, faultFound_d;
    logic [S-1:0]      rowFlags_q, rowFlags_d;
    logic [S-1:0]      colFlags_q, colFlags_d;
    logic [ADDR_WIDTH-1:0] writeAddr_q, writeAddr_d;

    logic [CNT_W-1:0]  rowCount [S];
    logic [CNT_W-1:0]  colCount [S];
    logic [S-1:0]      rowFlagsNext;
    logic [S-1:0]      colFlagsNext;
    logic              writing;

    // State and datapath registers; reset clears the map, flags and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            testType_q    <= 1'b0;
            testCounter_q <= '0;
            choose_q      <= 1'b0;
            faultMap_q    <= '0;
            faultFound_q  <= 1'b0;
            rowFlags_q    <= '0;
            colFlags_q    <= '0;
            writeAddr_q   <= '0;
        end else begin
            state_q       <= state_d;
            testType_q    <= testType_d;
            testCounter_q <= testCounter_d;
            choose_q      <= choose_d;
            faultMap_q    <= faultMap_d;
            faultFound_q  <= faultFound_d;
            rowFlags_q    <= rowFlags_d;
            colFlags_q    <= colFlags_d;
            writeAddr_q   <= writeAddr_d;
        end
    end

    // Count faulty PEs per row and column and flag lines at the threshold.
    always_comb begin
        for (int i = 0; i < S; i++) begin
            rowCount[i] = '0;
            colCount[i] = '0;
        end
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S; c++) begin
                rowCount[r] = rowCount[r] + CNT_W'(faultMap_q[r*S + c]);
                colCount[c] = colCount[c] + CNT_W'(faultMap_q[r*S + c]);
            end
        end
        for (int i = 0; i < S; i++) begin
            rowFlagsNext[i] = (rowCount[i] >= LINE_THRESH);
            colFlagsNext[i] = (colCount[i] >= LINE_THRESH);
        end
    end

    // Sequencing: pattern stepping, mismatch accumulation and eNVM write walk.
    always_comb begin
        state_d       = state_q;
        testType_d    = testType_q;
        testCounter_d = testCounter_q;
        choose_d      = choose_q;
        faultMap_d    = faultMap_q;
        faultFound_d  = faultFound_q;
        rowFlags_d    = rowFlags_q;
        colFlags_d    = colFlags_q;
        writeAddr_d   = writeAddr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    testType_d    = bus.test_type_in;
                    testCounter_d = '0;
                    choose_d      = 1'b0;
                    faultMap_d    = '0;
                    faultFound_d  = 1'b0;
                    rowFlags_d    = '0;
                    colFlags_d    = '0;
                    writeAddr_d   = '0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.result_valid) begin
                    faultMap_d   = faultMap_q | bus.pe_mismatch;
                    faultFound_d = faultFound_q | (|bus.pe_mismatch);
                    if (!testType_q) begin
                        if (testCounter_q == SA_LAST) begin
                            state_d = ST_EVAL;
                        end else begin
                            testCounter_d = testCounter_q + PAT_ONE;
                            state_d       = ST_REQ;
                        end
                    end else if (!choose_q) begin
                        choose_d = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        choose_d = 1'b0;
                        if (testCounter_q == TD_LAST) begin
                            state_d = ST_EVAL;
                        end else begin
                            testCounter_d = testCounter_q + PAT_ONE;
                            state_d       = ST_REQ;
                        end
                    end
                end
            end
            ST_EVAL: begin
                rowFlags_d  = rowFlagsNext;
                colFlags_d  = colFlagsNext;
                writeAddr_d = '0;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                if (writeAddr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    writeAddr_d = writeAddr_q + ADDR_ONE;
                end
            end
            ST_DONE: begin
                testCounter_d = '0;
                choose_d      = 1'b0;
                writeAddr_d   = '0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign writing = (state_q == ST_WRITE);

    // Isolated PEs of the row being written, suppressed by line flags.
    always_comb begin
        bus.single_pe_detection = '0;
        if (writing && !rowFlags_q[writeAddr_q]) begin
            bus.single_pe_detection =
                faultMap_q[int'(writeAddr_q)*S +: S] & ~colFlags_q;
        end
    end

    assign bus.test_type              = testType_q;
    assign bus.test_counter           = testCounter_q;
    assign bus.TD_answer_choose       = choose_q;
    assign bus.pattern_req            = (state_q == ST_REQ);
    assign bus.detection_en           = writing;
    assign bus.detection_addr         = writing ? writeAddr_q : '0;
    assign bus.row_fault_detection    = writing ? rowFlags_q : '0;
    assign bus.column_fault_detection = writing ? colFlags_q : '0;
    assign bus.busy                   = (state_q != ST_IDLE);
    assign bus.done                   = (state_q == ST_DONE);
    assign bus.fault_found            = faultFound_q;
endmodule

// File: tb/tb_bist_fault_collector.sv
// Directed self-checking bench for bist_fault_collector.
module tb_bist_fault_collector;
    localparam int S    = 8;
    localparam int AW   = 3;
    localparam int SA_D = 12;
    localparam int TD_D = 18;
    localparam int PCW  = 5;

    logic clk;
    logic rst;
    int   cycleCount;
    int   checkCount;
    int   errorCount;

    logic [63:0] stepMismatch [36];
    logic [7:0]  expSingle [8];
    logic [7:0]  expRow;
    logic [7:0]  expCol;
    logic        expFound;

    bist_fault_collector_if #(
        .SYSTOLIC_SIZE(S), .ADDR_WIDTH(AW),
        .SA_TEST_PATTERN_DEPTH(SA_D), .TD_TEST_PATTERN_DEPTH(TD_D),
        .MAX_PATTERN_ADDR_WIDTH(PCW)
    ) bus ();

    bist_fault_collector #(
        .SYSTOLIC_SIZE(S), .ADDR_WIDTH(AW),
        .SA_TEST_PATTERN_DEPTH(SA_D), .TD_TEST_PATTERN_DEPTH(TD_D),
        .MAX_PATTERN_ADDR_WIDTH(PCW), .LINE_FAULT_THRESHOLD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to measure run length.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearPlan();
        for (int i = 0; i < 36; i++) stepMismatch[i] = '0;
        for (int i = 0; i < 8; i++) expSingle[i] = '0;
        expRow   = '0;
        expCol   = '0;
        expFound = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " pattern_req"}, 64'(bus.pattern_req), 64'd0);
        checkOutput({name, " busy"}, 64'(bus.busy), 64'd0);
        checkOutput({name, " done"}, 64'(bus.done), 64'd0);
        checkOutput({name, " test_counter"}, 64'(bus.test_counter), 64'd0);
        checkOutput({name, " choose"}, 64'(bus.TD_answer_choose), 64'd0);
        checkOutput({name, " test_type"}, 64'(bus.test_type), 64'd0);
        checkOutput({name, " fault_found"}, 64'(bus.fault_found), 64'd0);
        checkOutput({name, " detection_en"}, 64'(bus.detection_en), 64'd0);
        checkOutput({name, " detection_addr"}, 64'(bus.detection_addr), 64'd0);
        checkOutput({name, " single"}, 64'(bus.single_pe_detection), 64'd0);
        checkOutput({name, " rowflags"}, 64'(bus.row_fault_detection), 64'd0);
        checkOutput({name, " colflags"}, 64'(bus.column_fault_detection), 64'd0);
    endtask

    // One complete run: start, answer every pattern_req from the plan,
    // then check the write phase, done pulse and final status.
    task automatic applyStimulus(input string name, input logic tdMode, input int latency,
                                 input logic holdValid, input int abortAt);
        int             nSteps;
        int             c0;
        int             waitCycles;
        logic [PCW-1:0] expCounter;
        logic           expChoose;
        logic           sawEn;

        nSteps = tdMode ? 2 * TD_D : SA_D;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.test_type_in = tdMode;
        c0               = cycleCount;
        if (holdValid) bus.result_valid = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.test_type_in = ~tdMode;

        for (int k = 0; k < nSteps; k++) begin
            waitCycles = 0;
            while (bus.pattern_req !== 1'b1 && waitCycles < 8) begin
                @(negedge clk);
                waitCycles++;
            end
            if (bus.pattern_req !== 1'b1) begin
                checkOutput($sformatf("%s reqTimeout step %0d", name, k), 64'd0, 64'd1);
                bus.result_valid = 1'b0;
                return;
            end
            expCounter = tdMode ? PCW'(k / 2) : PCW'(k);
            expChoose  = tdMode ? ((k % 2) == 1) : 1'b0;
            checkOutput($sformatf("%s counter step %0d", name, k),
                        64'(bus.test_counter), 64'(expCounter));
            checkOutput($sformatf("%s choose step %0d", name, k),
                        64'(bus.TD_answer_choose), 64'(expChoose));
            if (k == 0) begin
                checkOutput({name, " test_type"}, 64'(bus.test_type), 64'(tdMode));
                checkOutput({name, " fault_found cleared"}, 64'(bus.fault_found), 64'd0);
            end

            if (k == abortAt) begin
                rst = 1'b1;
                @(negedge clk);
                checkAllZero({name, " after reset"});
                rst   = 1'b0;
                sawEn = 1'b0;
                repeat (12) begin
                    @(negedge clk);
                    sawEn = sawEn | bus.detection_en | bus.pattern_req;
                end
                checkOutput({name, " quiet after abort"}, 64'(sawEn), 64'd0);
                return;
            end

            if (holdValid) begin
                bus.pe_mismatch = stepMismatch[k];
                if (k == 4) bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                @(negedge clk);
            end else begin
                repeat (latency) @(negedge clk);
                bus.result_valid = 1'b1;
                bus.pe_mismatch  = stepMismatch[k];
                @(negedge clk);
                bus.result_valid = 1'b0;
                bus.pe_mismatch  = '1;
            end
        end

        if (holdValid) bus.pe_mismatch = '1;
        checkOutput({name, " eval no write"}, 64'(bus.detection_en), 64'd0);
        checkOutput({name, " eval no req"}, 64'(bus.pattern_req), 64'd0);

        for (int a = 0; a < S; a++) begin
            @(negedge clk);
            bus.start = (holdValid && a == 3);
            checkOutput($sformatf("%s en addr %0d", name, a), 64'(bus.detection_en), 64'd1);
            checkOutput($sformatf("%s addr %0d", name, a), 64'(bus.detection_addr), 64'(a));
            checkOutput($sformatf("%s single addr %0d", name, a),
                        64'(bus.single_pe_detection), 64'(expSingle[a]));
            checkOutput($sformatf("%s rowflags addr %0d", name, a),
                        64'(bus.row_fault_detection), 64'(expRow));
            checkOutput($sformatf("%s colflags addr %0d", name, a),
                        64'(bus.column_fault_detection), 64'(expCol));
        end

        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({name, " done pulse"}, 64'(bus.done), 64'd1);
        checkOutput({name, " no write in done"}, 64'(bus.detection_en), 64'd0);
        if (latency == 1) begin
            checkOutput({name, " run length"}, 64'(cycleCount - c0),
                        tdMode ? 64'd82 : 64'd34);
        end

        @(negedge clk);
        checkOutput({name, " done cleared"}, 64'(bus.done), 64'd0);
        checkOutput({name, " idle"}, 64'(bus.busy), 64'd0);
        checkOutput({name, " fault_found"}, 64'(bus.fault_found), 64'(expFound));
        checkOutput({name, " counter back to 0"}, 64'(bus.test_counter), 64'd0);
        checkOutput({name, " choose back to 0"}, 64'(bus.TD_answer_choose), 64'd0);
        bus.result_valid = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        checkCount       = 0;
        errorCount       = 0;
        cycleCount       = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.test_type_in = 1'b0;
        bus.result_valid = 1'b0;
        bus.pe_mismatch  = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        clearPlan();
        applyStimulus("sa_clean", 1'b0, 1, 1'b0, -1);

        clearPlan();
        stepMismatch[7][21] = 1'b1;
        expSingle[2]        = 8'b0010_0000;
        expFound            = 1'b1;
        applyStimulus("td_single", 1'b1, 1, 1'b0, -1);

        clearPlan();
        stepMismatch[2][32] = 1'b1;
        stepMismatch[9][38] = 1'b1;
        expRow              = 8'b0001_0000;
        expFound            = 1'b1;
        applyStimulus("sa_row", 1'b0, 3, 1'b0, -1);

        clearPlan();
        stepMismatch[0][11]  = 1'b1;
        stepMismatch[20][51] = 1'b1;
        stepMismatch[35][7]  = 1'b1;
        expCol               = 8'b0000_1000;
        expSingle[0]         = 8'b1000_0000;
        expFound             = 1'b1;
        applyStimulus("td_col", 1'b1, 2, 1'b0, -1);

        clearPlan();
        stepMismatch[11][63] = 1'b1;
        expSingle[7]         = 8'b1000_0000;
        expFound             = 1'b1;
        applyStimulus("sa_hold", 1'b0, 1, 1'b1, -1);

        clearPlan();
        stepMismatch[1][10] = 1'b1;
        applyStimulus("sa_abort", 1'b0, 1, 1'b0, 5);

        clearPlan();
        applyStimulus("sa_fresh", 1'b0, 1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
